// File: rtl/pe_array_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pe_array_stream
//  Purpose  : N_PE multiply-accumulate lanes sharing one broadcast activation,
//             each lane with its own weight. After cfg_acc_len beats, every
//             enabled lane is shifted, saturated and optionally ReLU-clamped.
//             Lanes then drain one at a time over a valid/ready stream.
//  Ports    : clk, rst (sync, active-high)
//             start, cfg_acc_len, cfg_shift, cfg_relu, lane_mask : job config
//             in_valid/in_ready, in_act, in_wgt : input beat stream
//             out_valid/out_ready, out_data, out_lane, out_last : result stream
//             busy : high whenever a job is in progress
//  Option   : PEA_STREAM_BIAS_EN adds cfg_bias; accumulators then start at
//             sext(bias_i) << cfg_shift instead of 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_array_stream #(
  parameter int N_PE   = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16,
  parameter int LANE_W = $clog2(N_PE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       cfg_acc_len,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  input  logic [N_PE-1:0]        lane_mask,
`ifdef PEA_STREAM_BIAS_EN
  input  logic [N_PE*DATA_W-1:0] cfg_bias,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_act,
  input  logic [N_PE*DATA_W-1:0] in_wgt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [LANE_W-1:0]      out_lane,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                   state_q;
  logic [CNT_W-1:0]         len_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic [N_PE-1:0]          mask_q;
  logic signed [ACC_W-1:0]  acc_q    [N_PE];
  logic signed [ACC_W-1:0]  acc_d    [N_PE];
  logic signed [ACC_W-1:0]  acc_init [N_PE];
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_data_q;
  logic [LANE_W-1:0]        out_lane_q;
  logic                     out_last_q;
  logic                     busy_q;

  logic                     w_in_fire;
  logic                     w_out_fire;
  logic signed [DATA_W-1:0] w_act;
  logic [LANE_W-1:0]        w_first_lane;
  logic [LANE_W-1:0]        w_hi_lane;
  logic [LANE_W-1:0]        w_next_lane;

  assign w_in_fire  = in_valid & in_ready_q;
  assign w_out_fire = out_valid_q & out_ready;
  assign w_act      = in_act;

  // Shift, saturate to DATA_W, then ReLU (ReLU sees the saturated value).
  function automatic logic [DATA_W-1:0] f_post(input logic signed [ACC_W-1:0] a,
                                               input logic [4:0]              sh,
                                               input logic                    relu);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       r;
    s = a >>> sh;
    if (s > c_sat_max)      r = c_sat_max[DATA_W-1:0];
    else if (s < c_sat_min) r = c_sat_min[DATA_W-1:0];
    else                    r = s[DATA_W-1:0];
    if (relu && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  // Lane selection: lowest enabled, highest enabled, and the next enabled
  // lane above the current pointer (lets the drain skip holes with no bubble).
  always_comb begin
    w_first_lane = '0;
    w_hi_lane    = '0;
    w_next_lane  = '0;
    for (int i = N_PE - 1; i >= 0; i--) begin
      if (mask_q[i]) w_first_lane = LANE_W'(i);
      if (mask_q[i] && (i > int'(out_lane_q))) w_next_lane = LANE_W'(i);
    end
    for (int i = 0; i < N_PE; i++) begin
      if (mask_q[i]) w_hi_lane = LANE_W'(i);
    end
  end

  for (genvar g = 0; g < N_PE; g++) begin : g_lane
    logic signed [DATA_W-1:0]   w_wgt;
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_wgt    = in_wgt[g*DATA_W +: DATA_W];
    assign w_prod   = (2*DATA_W)'(w_act) * (2*DATA_W)'(w_wgt);
    assign acc_d[g] = (w_in_fire && mask_q[g]) ? acc_q[g] + ACC_W'(w_prod) : acc_q[g];
`ifdef PEA_STREAM_BIAS_EN
    logic signed [DATA_W-1:0] w_bias;
    assign w_bias      = cfg_bias[g*DATA_W +: DATA_W];
    assign acc_init[g] = lane_mask[g] ? (ACC_W'(w_bias) <<< cfg_shift) : '0;
`else
    assign acc_init[g] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      mask_q      <= '0;
      for (int i = 0; i < N_PE; i++) acc_q[i] <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (|lane_mask)) begin
            len_q      <= (cfg_acc_len == '0) ? CNT_W'(1) : cfg_acc_len;
            shift_q    <= cfg_shift;
            relu_q     <= cfg_relu;
            mask_q     <= lane_mask;
            cnt_q      <= '0;
            for (int i = 0; i < N_PE; i++) acc_q[i] <= acc_init[i];
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACC;
          end
        end
        S_ACC: begin
          for (int i = 0; i < N_PE; i++) acc_q[i] <= acc_d[i];
          if (w_in_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) begin
              // First result is taken from the post-update accumulator so it
              // is valid the very next cycle.
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_lane_q  <= w_first_lane;
              out_data_q  <= f_post(acc_d[w_first_lane], shift_q, relu_q);
              out_last_q  <= (w_first_lane == w_hi_lane);
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              out_lane_q <= w_next_lane;
              out_data_q <= f_post(acc_q[w_next_lane], shift_q, relu_q);
              out_last_q <= (w_next_lane == w_hi_lane);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/pe_array_stream.md
Name: pe_array_stream

Overview:
- Parametrised successor to the fixed-width PE array: N_PE MAC lanes share one broadcast activation; each lane takes its own weight.
- Each lane accumulates cfg_acc_len beats, then a post-processing stage applies arithmetic shift, saturation and optional ReLU.
- Results drain one lane at a time over a valid/ready stream, so the output no longer needs a wide parallel bus.
- Sits between the line-buffer/filter feeders and the output writeback buffer.

Parameters:
- N_PE, 8, number of MAC lanes (>=2).
- DATA_W, 16, signed activation/weight/output width.
- ACC_W, 40, signed accumulator width (>= 2*DATA_W).
- CNT_W, 16, width of beat counter and cfg_acc_len.
- LANE_W, $clog2(N_PE), lane index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle job start pulse; honoured only in IDLE.
- cfg_acc_len  in  CNT_W  beats per job; 0 is treated as 1.
- cfg_shift  in  5  arithmetic right shift applied to the accumulator before saturation.
- cfg_relu  in  1  when 1, negative results are clamped to 0.
- lane_mask  in  N_PE  enabled lanes (bit i = lane i).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_act  in  DATA_W  signed activation, broadcast to all lanes.
- in_wgt  in  N_PE*DATA_W  packed signed weights; lane i = bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  processed lane result.
- out_lane  out  LANE_W  lane index of out_data.
- out_last  out  1  marks the last enabled lane of the job.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE; all accumulators, counters and latched config clear to 0.
  - in_ready, out_valid, out_last, busy, out_data and out_lane all reset to 0.
  - Reset overrides every other event in the same cycle, including a reset asserted mid-job.
- FSM states: IDLE, ACC, DRAIN.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start with lane_mask!=0: latch cfg_acc_len (0 becomes 1), cfg_shift, cfg_relu and lane_mask; clear all accumulators and the beat counter; go to ACC.
  - start with lane_mask==0 is ignored.
  - in_valid in IDLE is never consumed.
- ACC:
  - in_ready=1.
  - On each handshake, every enabled lane does acc_i <= acc_i + sext(in_act*in_wgt_i), using a full 2*DATA_W signed product; disabled lanes hold their value.
  - Accumulation wraps modulo 2^ACC_W; no overflow detection.
  - Beat counter increments per handshake.
  - On the handshake where count == len-1, go to DRAIN; in_ready is 0 from the next cycle.
- DRAIN:
  - Lane pointer starts at the lowest enabled lane.
  - out_valid=1 the cycle after the final accepted beat (1-cycle latency).
  - out_data = ReLU(sat_DATA_W(acc_ptr >>> shift)). Saturation limits are -2^(DATA_W-1) to 2^(DATA_W-1)-1; ReLU applies after saturation.
  - out_lane = ptr.
  - out_last=1 when ptr is the highest enabled lane.
  - While out_valid & !out_ready: out_data, out_lane and out_last hold stable.
  - On handshake: ptr advances to the next enabled lane, skipping disabled lanes with no bubble cycles. After the out_last handshake, go to IDLE (busy=0 the next cycle).
- Accumulators hold their values through DRAIN; config inputs may change freely once latched.
- start while busy is ignored; start on the same cycle as the out_last handshake is also ignored.
- Throughput: 1 input beat/cycle in ACC; 1 output/cycle in DRAIN with out_ready held high.

Optional Feature:
- Macro: PEA_STREAM_BIAS_EN.
- Defined:
  - Adds input port cfg_bias (N_PE*DATA_W, packed per lane like in_wgt).
  - At start, each accumulator is initialised to sext(bias_i) << cfg_shift instead of 0, so the bias is added in output scale.
  - Disabled lanes load 0.
- Undefined: port absent; accumulators initialise to 0.

Test Plan:
- Basic job: mask=8'hFF, len=3, shift=0, relu=0, act=2,3,4, wgt_i=i+1 on every beat -> outputs 9,18,27,...,72 on lanes 0..7; out_last only on lane 7; first out_valid 1 cycle after the 3rd beat.
- Sparse mask: mask=8'b0000_0101, len=1, act=5, all wgt=10 -> exactly two outputs: (lane0,50), then (lane2,50,last); no gap cycle between them with out_ready=1.
- Arithmetic:
  - act=-32768, wgt=-32768, len=2, shift=0 -> out_data=32767 (saturated).
  - act=100, wgt=-3, len=1: relu=0 -> -300; relu=1 -> 0.
  - act=100, wgt=3, shift=2 -> 75.
- Backpressure: hold out_ready=0 for 5 cycles mid-drain -> out_valid stays 1 and data/lane stay stable; after release the sequence resumes with no loss or duplication.
- Control corners:
  - len=0 behaves as len=1.
  - start during ACC/DRAIN is ignored.
  - in_valid in IDLE is not consumed.
  - start with mask=0 leaves busy=0.
- Reset mid-ACC after 2 of 4 beats -> next cycle all outputs 0 and IDLE; a new job then gives correct results from cleared accumulators.
